// File: rtl/key_pkg.sv
// Shared types and default timing constants for the push-button front-end.
// Latency: n/a (package). Backpressure: n/a.
// Contents: play_mode_t (AudDSP mode), k2_state_t (key-2 press FSM), default timing, mode rotation helper.
package key_pkg;

    typedef enum logic [1:0] {
        FAST       = 2'd0,
        SLOW_CONST = 2'd1,
        SLOW_LIN   = 2'd2
    } play_mode_t;

    typedef enum logic [1:0] {
        K_IDLE = 2'd0,
        K_HELD = 2'd1,
        K_LONG = 2'd2
    } k2_state_t;

    // 10 ms debounce and 1 s long-press at a 50 MHz system clock
    localparam int DEF_DEB_CYCLES  = 500000;
    localparam int DEF_LONG_CYCLES = 50000000;
    localparam int DEF_CNT_W       = 26;
    localparam int DEF_SPEED_MAX   = 8;

    // FAST -> SLOW_CONST -> SLOW_LIN -> FAST
    function automatic play_mode_t next_mode(input play_mode_t m);
        case (m)
            FAST:       return SLOW_CONST;
            SLOW_CONST: return SLOW_LIN;
            default:    return FAST;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus debounce counter for one active-low push-button.
// Latency: raw edge to stable flip and strobe = 2 + DEB_CYCLES cycles. Backpressure: none (free-running strobes).
// Ports: i_clk, i_rst (async high), i_key_n (raw, low = pressed); o_stable (debounced level), o_press / o_release (1-cycle strobes).
module key_debounce
    import key_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_stable,
    output logic o_press,
    output logic o_release
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync_0;
    logic             r_sync_1;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync_0  <= 1'b1;
            r_sync_1  <= 1'b1;
            r_stable  <= 1'b1;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync_0  <= i_key_n;
            r_sync_1  <= r_sync_0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (r_sync_1 != r_stable) begin
                if (r_cnt == DEB_LAST) begin
                    // Level has differed for DEB_CYCLES consecutive cycles: accept it.
                    r_stable  <= r_sync_1;
                    r_cnt     <= '0;
                    r_press   <= r_stable;   // was released, now pressed
                    r_release <= ~r_stable;  // was pressed, now released
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                // Any return to the accepted level restarts the qualification window.
                r_cnt <= '0;
            end
        end
    end

    assign o_stable  = r_stable;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/key_ctrl.sv
// Debounced key front-end: press pulses for keys 0/1, short/long key-2 handling, speed and mode registers.
// Latency: raw edge to o_key_0/1 = 2 + DEB_CYCLES + 1 cycles; key-2 release to o_key_2 likewise. Backpressure: none.
// Ports: i_clk, i_rst (async high), i_key_{0,1,2}_n raw buttons, i_lock freezes speed/mode; o_key_{0,1,2} pulses, o_speed, o_mode.
module key_ctrl
    import key_pkg::*;
#(
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SPEED_MAX   = DEF_SPEED_MAX
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_0_n,
    input  logic       i_key_1_n,
    input  logic       i_key_2_n,
    input  logic       i_lock,
    output logic       o_key_0,
    output logic       o_key_1,
    output logic       o_key_2,
    output logic [3:0] o_speed,
    output logic [1:0] o_mode
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [3:0]       SPD_MAX   = 4'(SPEED_MAX);

    logic w_stable_0, w_press_0, w_release_0;
    logic w_stable_1, w_press_1, w_release_1;
    logic w_stable_2, w_press_2, w_release_2;
    logic w_unused;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_key_n(i_key_0_n),
        .o_stable(w_stable_0), .o_press(w_press_0), .o_release(w_release_0)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_key_n(i_key_1_n),
        .o_stable(w_stable_1), .o_press(w_press_1), .o_release(w_release_1)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_key_n(i_key_2_n),
        .o_stable(w_stable_2), .o_press(w_press_2), .o_release(w_release_2)
    );

    // Keys 0/1 only report presses; their level and release strobe are not needed here.
    assign w_unused = ^{w_stable_0, w_release_0, w_stable_1, w_release_1};

    k2_state_t        r_state;
    logic [CNT_W-1:0] r_hold;
    logic             r_key_0;
    logic             r_key_1;
    logic             r_key_2;
    logic [3:0]       r_speed;
    play_mode_t       r_mode;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= K_IDLE;
            r_hold  <= '0;
            r_key_0 <= 1'b0;
            r_key_1 <= 1'b0;
            r_key_2 <= 1'b0;
            r_speed <= 4'd1;
            r_mode  <= FAST;
        end else begin
            r_key_0 <= w_press_0;
            r_key_1 <= w_press_1;
            r_key_2 <= 1'b0;
            case (r_state)
                K_IDLE: begin
                    if (w_press_2) begin
                        r_state <= K_HELD;
                        r_hold  <= '0;
                    end
                end
                K_HELD: begin
                    // Reaching the long threshold wins over a release in the same cycle.
                    if (r_hold == HOLD_LAST) begin
                        r_state <= K_LONG;
                        if (!i_lock) begin
                            r_mode  <= next_mode(r_mode);
                            r_speed <= 4'd1;
                        end
                    end else if (w_release_2) begin
                        r_state <= K_IDLE;
                        r_key_2 <= 1'b1;
                        if (!i_lock) begin
                            r_speed <= (r_speed == SPD_MAX) ? 4'd1 : r_speed + 4'd1;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                K_LONG: begin
                    // Wait on the level, not the strobe: the release may coincide with the long action.
                    if (w_stable_2) begin
                        r_state <= K_IDLE;
                    end
                end
                default: r_state <= K_IDLE;
            endcase
        end
    end

    assign o_key_0 = r_key_0;
    assign o_key_1 = r_key_1;
    assign o_key_2 = r_key_2;
    assign o_speed = r_speed;
    assign o_mode  = r_mode;

endmodule

// File: tb/tb_key_ctrl.sv
// Bench for key_ctrl with short debounce/long-press timing.
// Latency: n/a. Backpressure: n/a.
// A cycle-level reference of the button rules runs alongside directed sequences, a press table and random stimulus.
module tb_key_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 16;
    localparam int SMAX = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       raw_n [3];
    logic       lock;
    logic       o_key_0, o_key_1, o_key_2;
    logic [3:0] o_speed;
    logic [1:0] o_mode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_ctrl #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .CNT_W(26), .SPEED_MAX(SMAX)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_key_0_n(raw_n[0]), .i_key_1_n(raw_n[1]), .i_key_2_n(raw_n[2]),
        .i_lock(lock),
        .o_key_0(o_key_0), .o_key_1(o_key_1), .o_key_2(o_key_2),
        .o_speed(o_speed), .o_mode(o_mode)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Per key: the synchronised level is the raw level seen two edges earlier; it is accepted
    // once it has disagreed with the accepted level on DEB consecutive edges.
    int samp1 [3], samp2 [3], acc [3], run [3], pr_ev [3], rl_ev [3];
    int e_key [3];
    int e_speed, e_mode;
    int k2_phase;   // 0 waiting, 1 held (age counted), 2 long action done, waiting release
    int k2_age;

    always @(posedge clk) begin
        int p2, r2, a2;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                samp1[k] = 1; samp2[k] = 1; acc[k] = 1; run[k] = 0;
                pr_ev[k] = 0; rl_ev[k] = 0; e_key[k] = 0;
            end
            e_speed = 1; e_mode = 0; k2_phase = 0; k2_age = 0;
        end else begin
            p2 = pr_ev[2]; r2 = rl_ev[2]; a2 = acc[2];
            e_key[0] = pr_ev[0];
            e_key[1] = pr_ev[1];
            e_key[2] = 0;
            if (k2_phase == 0) begin
                if (p2 != 0) begin k2_phase = 1; k2_age = 0; end
            end else if (k2_phase == 1) begin
                k2_age++;
                if (k2_age == LONG) begin
                    k2_phase = 2;
                    if (!lock) begin e_mode = (e_mode + 1) % 3; e_speed = 1; end
                end else if (r2 != 0) begin
                    k2_phase = 0;
                    e_key[2] = 1;
                    if (!lock) e_speed = (e_speed % SMAX) + 1;
                end
            end else begin
                if (a2 == 1) k2_phase = 0;
            end
            for (int k = 0; k < 3; k++) begin
                pr_ev[k] = 0; rl_ev[k] = 0;
                if (samp2[k] != acc[k]) begin
                    run[k]++;
                    if (run[k] == DEB) begin
                        acc[k] = samp2[k];
                        run[k] = 0;
                        pr_ev[k] = (acc[k] == 0) ? 1 : 0;
                        rl_ev[k] = (acc[k] == 1) ? 1 : 0;
                    end
                end else begin
                    run[k] = 0;
                end
                samp2[k] = samp1[k];
                samp1[k] = int'(raw_n[k]);
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(posedge clk) begin
        #1;
        chk("key0", int'(o_key_0), e_key[0]);
        chk("key1", int'(o_key_1), e_key[1]);
        chk("key2", int'(o_key_2), e_key[2]);
        chk("speed", int'(o_speed), e_speed);
        chk("mode", int'(o_mode), e_mode);
    end

    function automatic logic pulse_of(input int idx);
        return (idx == 0) ? o_key_0 : (idx == 1) ? o_key_1 : o_key_2;
    endfunction

    // Hold key idx low for low_cyc edges, watch obs edges; report first pulse edge, pulse count, mode change edge.
    task automatic press_obs(input int idx, input int low_cyc, input int obs,
                             output int first, output int np, output int mode_edge);
        int m0;
        m0 = int'(o_mode);
        first = -1; np = 0; mode_edge = -1;
        @(negedge clk);
        raw_n[idx] = 1'b0;
        for (int c = 1; c <= obs; c++) begin
            @(posedge clk); #1;
            if (pulse_of(idx)) begin
                np++;
                if (first < 0) first = c;
            end
            if (mode_edge < 0 && int'(o_mode) != m0) mode_edge = c;
            if (c == low_cyc) begin
                @(negedge clk);
                raw_n[idx] = 1'b1;
            end
        end
    endtask

    typedef struct {
        int hold; bit lk; int pulses; int pulse_edge; int speed; int mode; int mode_edge;
    } row_t;

    row_t rows [20];
    int   first, np, medge;
    int   rem [3];

    initial begin
        rst = 1'b1; lock = 1'b0;
        raw_n[0] = 1'b1; raw_n[1] = 1'b1; raw_n[2] = 1'b1;

        rows[0]  = '{8, 0, 1, 15, 2, 0, -1};
        rows[1]  = '{8, 0, 1, 15, 3, 0, -1};
        rows[2]  = '{8, 0, 1, 15, 4, 0, -1};
        rows[3]  = '{8, 0, 1, 15, 5, 0, -1};
        rows[4]  = '{30, 0, 0, -1, 1, 1, 23};
        rows[5]  = '{8, 0, 1, 15, 2, 1, -1};
        rows[6]  = '{8, 0, 1, 15, 3, 1, -1};
        rows[7]  = '{8, 0, 1, 15, 4, 1, -1};
        rows[8]  = '{8, 0, 1, 15, 5, 1, -1};
        rows[9]  = '{8, 0, 1, 15, 6, 1, -1};
        rows[10] = '{8, 0, 1, 15, 7, 1, -1};
        rows[11] = '{8, 0, 1, 15, 8, 1, -1};
        rows[12] = '{8, 0, 1, 15, 1, 1, -1};
        rows[13] = '{30, 0, 0, -1, 1, 2, 23};
        rows[14] = '{8, 0, 1, 15, 2, 2, -1};
        rows[15] = '{30, 0, 0, -1, 1, 0, 23};
        rows[16] = '{8, 0, 1, 15, 2, 0, -1};
        rows[17] = '{8, 1, 1, 15, 2, 0, -1};
        rows[18] = '{30, 1, 0, -1, 2, 0, -1};
        rows[19] = '{8, 0, 1, 15, 3, 0, -1};

        repeat (3) @(negedge clk);
        chk("rst_speed", int'(o_speed), 1);
        chk("rst_mode", int'(o_mode), 0);
        chk("rst_key2", int'(o_key_2), 0);
        rst = 1'b0;

        // Key 0: one pulse 7 edges after the falling edge, nothing on release.
        press_obs(0, 20, 40, first, np, medge);
        chk("k0_edge", first, 7);
        chk("k0_count", np, 1);

        // Key 1 bounce 0,1,0,1 then steady low from edge 5: pulse at edge 11 only.
        first = -1; np = 0;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            raw_n[1] = (c <= 4) ? logic'(c % 2 == 0) : logic'(c > 20);
            @(posedge clk); #1;
            if (o_key_1) begin
                np++;
                if (first < 0) first = c;
            end
        end
        chk("k1_edge", first, 11);
        chk("k1_count", np, 1);

        // Key 2 press table: short/long, wrap, mode rotation, lock.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lock = rows[i].lk;
            press_obs(2, rows[i].hold, rows[i].hold + 20, first, np, medge);
            chk("tbl_pulses", np, rows[i].pulses);
            chk("tbl_pulse_edge", first, rows[i].pulse_edge);
            chk("tbl_speed", int'(o_speed), rows[i].speed);
            chk("tbl_mode", int'(o_mode), rows[i].mode);
            chk("tbl_mode_edge", medge, rows[i].mode_edge);
            @(negedge clk);
            lock = 1'b0;
        end

        // Reset while key 2 is held (speed 3): abandon, then re-register as a fresh press.
        @(negedge clk);
        raw_n[2] = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_hold_speed", int'(o_speed), 1);
        chk("rst_hold_mode", int'(o_mode), 0);
        chk("rst_hold_key2", int'(o_key_2), 0);
        @(negedge clk);
        rst = 1'b0;
        first = -1; np = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (o_key_2) begin
                np++;
                if (first < 0) first = c;
            end
            if (c == 10) begin
                @(negedge clk);
                raw_n[2] = 1'b1;
            end
        end
        chk("post_rst_edge", first, 17);
        chk("post_rst_count", np, 1);
        chk("post_rst_speed", int'(o_speed), 2);

        // Random phase: glitches, short and long holds, lock toggling, occasional reset.
        for (int k = 0; k < 3; k++) rem[k] = 1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                rem[k]--;
                if (rem[k] <= 0) begin
                    raw_n[k] = ~raw_n[k];
                    rem[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                        : int'($urandom_range(4, 40));
                end
            end
            if ($urandom_range(0, 99) < 3) lock = ~lock;
            rst = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
